// File: rtl/music_pkg.sv
// Shared note/duration widths and note-handshake FSM encodings for the song reader and note player.
package music_pkg;

    localparam int NOTE_BITS = 6;
    localparam int DUR_BITS  = 6;
    localparam int STEP_BITS = 20;

    localparam logic [NOTE_BITS-1:0] NOTE_REST = '0;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        PLAY = 2'd1,
        GAP  = 2'd2,
        DONE = 2'd3
    } state_t;

endpackage

// File: rtl/frequency_rom.sv
// Note index to phase-accumulator step: round(440*2^((n-49)/12)*2^20/48000), note 0 (rest) = 0.
module frequency_rom
    import music_pkg::*;
(
    input  logic [NOTE_BITS-1:0] note,
    output logic [STEP_BITS-1:0] step
);

    // NOTE: the default assignment ahead of the case keeps this purely combinational (no latch).
    always_comb begin
        step = '0;
        case (note)
            6'd1:  step = 20'd601;   6'd2:  step = 20'd636;   6'd3:  step = 20'd674;   6'd4:  step = 20'd714;
            6'd5:  step = 20'd757;   6'd6:  step = 20'd802;   6'd7:  step = 20'd850;   6'd8:  step = 20'd900;
            6'd9:  step = 20'd954;   6'd10: step = 20'd1010;  6'd11: step = 20'd1070;  6'd12: step = 20'd1134;
            6'd13: step = 20'd1201;  6'd14: step = 20'd1273;  6'd15: step = 20'd1349;  6'd16: step = 20'd1429;
            6'd17: step = 20'd1514;  6'd18: step = 20'd1604;  6'd19: step = 20'd1699;  6'd20: step = 20'd1800;
            6'd21: step = 20'd1907;  6'd22: step = 20'd2021;  6'd23: step = 20'd2141;  6'd24: step = 20'd2268;
            6'd25: step = 20'd2403;  6'd26: step = 20'd2546;  6'd27: step = 20'd2697;  6'd28: step = 20'd2858;
            6'd29: step = 20'd3028;  6'd30: step = 20'd3208;  6'd31: step = 20'd3398;  6'd32: step = 20'd3600;
            6'd33: step = 20'd3815;  6'd34: step = 20'd4041;  6'd35: step = 20'd4282;  6'd36: step = 20'd4536;
            6'd37: step = 20'd4806;  6'd38: step = 20'd5092;  6'd39: step = 20'd5395;  6'd40: step = 20'd5715;
            6'd41: step = 20'd6055;  6'd42: step = 20'd6415;  6'd43: step = 20'd6797;  6'd44: step = 20'd7201;
            6'd45: step = 20'd7629;  6'd46: step = 20'd8083;  6'd47: step = 20'd8563;  6'd48: step = 20'd9072;
            6'd49: step = 20'd9612;  6'd50: step = 20'd10184; 6'd51: step = 20'd10789; 6'd52: step = 20'd11431;
            6'd53: step = 20'd12110; 6'd54: step = 20'd12830; 6'd55: step = 20'd13593; 6'd56: step = 20'd14402;
            6'd57: step = 20'd15258; 6'd58: step = 20'd16165; 6'd59: step = 20'd17127; 6'd60: step = 20'd18145;
            6'd61: step = 20'd19224; 6'd62: step = 20'd20367; 6'd63: step = 20'd21578;
            default: step = '0;
        endcase
    end

endmodule

// File: rtl/note_player.sv
// Plays one latched {note, duration} as a square-wave PCM stream and pulses note_done when finished.
// Define NOTE_GAP_EN to append one silent articulation beat (GAP) after every non-empty note.
module note_player
    import music_pkg::*;
#(
    parameter int PHASE_BITS  = 20,
    parameter int SAMPLE_BITS = 16,
    parameter int AMPLITUDE   = 8192
)(
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          play,
    input  logic                          new_note,
    input  logic [NOTE_BITS-1:0]          note,
    input  logic [DUR_BITS-1:0]           duration,
    input  logic                          beat,
    input  logic                          next_sample,
    output logic                          note_done,
    output logic signed [SAMPLE_BITS-1:0] sample,
    output logic                          sample_ready
);

    localparam logic signed [SAMPLE_BITS-1:0] AMP_POS = SAMPLE_BITS'(AMPLITUDE);
    localparam logic signed [SAMPLE_BITS-1:0] AMP_NEG = SAMPLE_BITS'(-AMPLITUDE);

    state_t                state;
    logic [NOTE_BITS-1:0]  note_q;
    logic [DUR_BITS-1:0]   beat_cnt;
    logic [PHASE_BITS-1:0] phase;
    logic [PHASE_BITS-1:0] step;
    logic [STEP_BITS-1:0]  rom_step;
    logic                  load;
    logic                  beat_en;
    logic                  advance;
    logic                  tone_en;

    frequency_rom u_frequency_rom (
        .note (note),
        .step (rom_step)
    );

    assign load      = (state == IDLE) && new_note;
    assign beat_en   = beat && play;
    assign advance   = (state == PLAY) && play;
    assign tone_en   = advance && (note_q != NOTE_REST);
    assign note_done = (state == DONE);

    // NOTE: state registers use non-blocking assignments and reset asynchronously on reset low.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state    <= IDLE;
            note_q   <= NOTE_REST;
            step     <= '0;
            beat_cnt <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (new_note) begin
                        note_q   <= note;
                        step     <= PHASE_BITS'(rom_step);
                        beat_cnt <= duration;
                        state    <= (duration == '0) ? DONE : PLAY;
                    end
                end
                PLAY: begin
                    if (beat_en) begin
                        beat_cnt <= beat_cnt - 1'b1;
                        if (beat_cnt == DUR_BITS'(1)) begin
`ifdef NOTE_GAP_EN
                            state <= GAP;
`else
                            state <= DONE;
`endif
                        end
                    end
                end
`ifdef NOTE_GAP_EN
                GAP: begin
                    if (beat_en) state <= DONE;
                end
`endif
                DONE:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    // Phase restarts at zero for each note so every tone begins on its positive half-cycle.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            phase <= '0;
        end else if (load) begin
            phase <= '0;
        end else if (next_sample && advance) begin
            phase <= phase + step;
        end
    end

    // The sample taken on a strobe reflects the phase before that strobe's advance.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sample       <= '0;
            sample_ready <= 1'b0;
        end else begin
            sample_ready <= next_sample;
            if (next_sample) begin
                sample <= tone_en ? (phase[PHASE_BITS-1] ? AMP_NEG : AMP_POS) : '0;
            end
        end
    end

endmodule

// File: tb/tb_note_player.sv
// Self-checking bench for note_player: note-level behavioural model compared every cycle plus directed literals.
module tb_note_player;

`ifdef NOTE_GAP_EN
    localparam int GAP_EXTRA = 1;
`else
    localparam int GAP_EXTRA = 0;
`endif
    localparam int BEAT_GAP    = 300;
    localparam int SAMPLE_DIV  = 4;
    localparam int AMP         = 8192;
    localparam int PHASE_MOD   = 1 << 20;

    logic               clk = 1'b0;
    logic               reset = 1'b1;
    logic               play = 1'b1;
    logic               new_note = 1'b0;
    logic [5:0]         note = '0;
    logic [5:0]         duration = '0;
    logic               beat = 1'b0;
    logic               next_sample = 1'b0;
    logic               note_done;
    logic signed [15:0] sample;
    logic               sample_ready;

    int errors = 0;
    int checks = 0;
    bit armed  = 1'b0;

    note_player dut (
        .clk          (clk),
        .reset        (reset),
        .play         (play),
        .new_note     (new_note),
        .note         (note),
        .duration     (duration),
        .beat         (beat),
        .next_sample  (next_sample),
        .note_done    (note_done),
        .sample       (sample),
        .sample_ready (sample_ready)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string name, input int actual, input int expected);
        checks++;
        if (actual != expected) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, actual, expected, $time);
        end
    endtask

    // Tuning law straight from the musical definition, in floating point.
    function automatic int freq_step(input int n);
        real f;
        if (n == 0) return 0;
        f = 440.0 * (2.0 ** ((n - 49) / 12.0)) * 1048576.0 / 48000.0;
        return $rtoi(f + 0.5);
    endfunction

    // Note-level model: a note is "busy" until it has heard duration(+gap) counted beats.
    bit m_busy = 0, m_done = 0, m_ready = 0, was_done = 0, sounding = 0;
    int m_sample = 0, m_phase = 0, m_step = 0, m_note = 0, m_dur = 0, m_beats = 0;

    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            m_busy = 0; m_done = 0; m_ready = 0; m_sample = 0; m_phase = 0;
            m_step = 0; m_note = 0; m_dur = 0; m_beats = 0;
        end else begin
            was_done = m_done;
            m_done   = 0;
            sounding = m_busy && play && (m_beats < m_dur);
            m_ready  = next_sample;
            if (next_sample) begin
                if (sounding && m_note != 0) m_sample = (m_phase >= PHASE_MOD / 2) ? -AMP : AMP;
                else                         m_sample = 0;
                if (sounding) m_phase = (m_phase + m_step) % PHASE_MOD;
            end
            if (m_busy) begin
                if (beat && play) begin
                    m_beats++;
                    if (m_beats == m_dur + GAP_EXTRA) begin
                        m_busy = 0;
                        m_done = 1;
                    end
                end
            end else if (!was_done && new_note) begin
                m_note  = int'(note);
                m_dur   = int'(duration);
                m_step  = freq_step(m_note);
                m_phase = 0;
                m_beats = 0;
                if (duration == 0) m_done = 1;
                else               m_busy = 1;
            end
        end
    end

    always @(negedge clk) begin
        if (armed) begin
            check("note_done", int'(note_done), int'(m_done));
            check("sample_ready", int'(sample_ready), int'(m_ready));
            check("sample", int'(sample), m_sample);
        end
    end

    // Free-running sample-rate strobe.
    initial begin
        int cnt = 0;
        forever begin
            @(posedge clk);
            #1;
            next_sample = (cnt % SAMPLE_DIV == 0);
            cnt++;
        end
    end

    // Run-length statistics of the nonzero samples of the current note.
    int nonzero_cnt, run_len, first_pos_run, first_neg_run;
    bit cur_pos;

    function automatic void clear_stats();
        nonzero_cnt = 0; run_len = 0; first_pos_run = 0; first_neg_run = 0; cur_pos = 0;
    endfunction

    function automatic void record();
        bit pos;
        if (!sample_ready || sample == 0) return;
        nonzero_cnt++;
        pos = (sample > 0);
        if (run_len != 0 && pos != cur_pos) begin
            if (cur_pos && first_pos_run == 0)  first_pos_run = run_len;
            if (!cur_pos && first_neg_run == 0) first_neg_run = run_len;
            run_len = 0;
        end
        cur_pos = pos;
        run_len++;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
        record();
    endtask

    task automatic wait_clks(input int n);
        repeat (n) tick();
    endtask

    task automatic give_beat();
        beat = 1'b1;
        tick();
        beat = 1'b0;
    endtask

    task automatic load(input int n, input int d);
        note     = 6'(n);
        duration = 6'(d);
        new_note = 1'b1;
        tick();
        new_note = 1'b0;
    endtask

    task automatic run_note(input string name, input int n, input int d,
                            input int pause_at, input int pause_len, input bit inject);
        int ticks = 0;
        bit done_seen = 0;
        clear_stats();
        load(n, d);
        if (d == 0) begin
            check({name, " done after load"}, int'(note_done), 1);
            tick();
            check({name, " done single pulse"}, int'(note_done), 0);
            return;
        end
        while (!done_seen && ticks < 20) begin
            wait_clks(BEAT_GAP);
            if (inject && ticks == 1) begin
                note = 6'd5; duration = 6'd1; new_note = 1'b1;
                tick();
                new_note = 1'b0; note = 6'(n); duration = 6'(d);
            end
            give_beat();
            ticks++;
            if (note_done) begin
                done_seen = 1;
            end else if (pause_len > 0 && ticks == pause_at) begin
                play = 1'b0;
            end else if (!play && ticks == pause_at + pause_len) begin
                check({name, " muted while paused"}, int'(sample), 0);
                play = 1'b1;
            end
        end
        check({name, " beat ticks to done"}, ticks, d + GAP_EXTRA + pause_len);
        tick();
        check({name, " done single pulse"}, int'(note_done), 0);
        wait_clks(8);
    endtask

    initial begin
        #3 reset = 1'b0;
        armed = 1'b1;
        wait_clks(3);
        check("reset note_done", int'(note_done), 0);
        check("reset sample", int'(sample), 0);
        check("reset sample_ready", int'(sample_ready), 0);
        reset = 1'b1;
        wait_clks(4);

        // A4 tone; a new_note mid-play must be ignored.
        run_note("a4", 49, 3, 0, 0, 1'b1);
        check("a4 first positive run", first_pos_run, 55);
        check("a4 first negative run", first_neg_run, 55);

        run_note("empty", 20, 0, 0, 0, 1'b0);
        check("empty stays silent", nonzero_cnt, 0);

        run_note("rest", 0, 2, 0, 0, 1'b0);
        check("rest stays silent", nonzero_cnt, 0);

        // Pause for three beat ticks after beat 2: seven ticks in total.
        run_note("pause", 49, 4, 2, 3, 1'b0);

        // Reset in the middle of a tone abandons it without note_done.
        clear_stats();
        load(49, 3);
        wait_clks(50);
        check("pre-reset tone audible", int'(sample != 0), 1);
        #2 reset = 1'b0;
        #1;
        check("mid-reset note_done", int'(note_done), 0);
        check("mid-reset sample", int'(sample), 0);
        wait_clks(3);
        reset = 1'b1;
        wait_clks(2);
        load(20, 0);
        check("load accepted after reset", int'(note_done), 1);
        wait_clks(4);

        armed = 1'b0;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
